// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-indexed PC, fills the IF/ID register from a
// combinational instruction memory, and handles redirect flush, halt and range faults.
module fetch_unit #(
   parameter int unsigned     PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     MEM_WORDS = 256,
   parameter logic [15:0]     HALT_WORD = 16'hFFFF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [PC_W-1:0] pc_o,
   input  logic [15:0]     ins_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   input  logic            id_ready_i,
   output logic            id_valid_o,
   output logic [15:0]     id_ins_o,
   output logic [PC_W-1:0] id_pc_o,
   output logic [PC_W-1:0] id_pc_plus1_o,
   output logic            halted_o,
   output logic            fault_o
);

   typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

   // One extra bit so a MEM_WORDS of 2**PC_W still compares correctly.
   localparam logic [PC_W:0] MemLimit = (PC_W + 1)'(MEM_WORDS);

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic            id_valid_q;
   logic [15:0]     id_ins_q;
   logic [PC_W-1:0] id_pc_q;
   logic [PC_W-1:0] id_pc_plus1_q;
   logic            halted_q;
   logic            fault_q;

   logic            slot_free;
   logic            pc_oob;
   logic [PC_W-1:0] pc_plus1;

   assign slot_free = !id_valid_q || id_ready_i;
   assign pc_oob    = ({1'b0, pc_q} >= MemLimit);
   assign pc_plus1  = pc_q + PC_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_ins_q      <= '0;
         id_pc_q       <= '0;
         id_pc_plus1_q <= '0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         case (state_q)
            StRun: begin
               if (redirect_i) begin
                  // Flush both the word in flight and whatever IF/ID still holds.
                  pc_q       <= redirect_pc_i;
                  id_valid_q <= 1'b0;
               end else if (pc_oob) begin
                  state_q <= StFault;
                  fault_q <= 1'b1;
                  if (slot_free) begin
                     id_valid_q <= 1'b0;
                  end
               end else if (slot_free) begin
                  id_ins_q      <= ins_i;
                  id_pc_q       <= pc_q;
                  id_pc_plus1_q <= pc_plus1;
                  id_valid_q    <= 1'b1;
                  pc_q          <= pc_plus1;
                  if (ins_i == HALT_WORD) begin
                     state_q  <= StHalt;
                     halted_q <= 1'b1;
                  end
               end
            end
            StHalt: begin
               if (id_ready_i) begin
                  id_valid_q <= 1'b0;
               end
               if (redirect_i) begin
                  state_q  <= StRun;
                  halted_q <= 1'b0;
                  pc_q     <= redirect_pc_i;
               end
            end
            StFault: begin
               if (id_ready_i) begin
                  id_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StFault;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign pc_o          = pc_q;
   assign id_valid_o    = id_valid_q;
   assign id_ins_o      = id_ins_q;
   assign id_pc_o       = id_pc_q;
   assign id_pc_plus1_o = id_pc_plus1_q;
   assign halted_o      = halted_q;
   assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

   localparam int unsigned MEM_WORDS = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pc_o;
   logic [15:0] ins_i;
   logic        redirect_i = 1'b0;
   logic [15:0] redirect_pc_i = '0;
   logic        id_ready_i = 1'b1;
   logic        id_valid_o;
   logic [15:0] id_ins_o;
   logic [15:0] id_pc_o;
   logic [15:0] id_pc_plus1_o;
   logic        halted_o;
   logic        fault_o;

   logic [15:0] mem [MEM_WORDS];

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [15:0] m_pc;
   logic        m_valid;
   logic [15:0] m_ins;
   logic [15:0] m_ipc;
   logic        m_halted;
   logic        m_fault;

   always #5 clk = ~clk;

   assign ins_i = (pc_o < 16'(MEM_WORDS)) ? mem[pc_o[7:0]] : 16'hBAD0;

   fetch_unit #(
      .PC_W     (16),
      .RESET_PC (16'h0000),
      .MEM_WORDS(MEM_WORDS),
      .HALT_WORD(16'hFFFF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_o         (pc_o),
      .ins_i        (ins_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .id_ready_i   (id_ready_i),
      .id_valid_o   (id_valid_o),
      .id_ins_o     (id_ins_o),
      .id_pc_o      (id_pc_o),
      .id_pc_plus1_o(id_pc_plus1_o),
      .halted_o     (halted_o),
      .fault_o      (fault_o)
   );

   task automatic model_reset();
      m_pc = 16'h0000; m_valid = 1'b0; m_ins = '0; m_ipc = '0;
      m_halted = 1'b0; m_fault = 1'b0;
   endtask

   // One clock of the fetch rules, applied to the inputs as they stand before the edge.
   task automatic model_step();
      logic        take;
      logic [15:0] word;
      take = !m_valid || id_ready_i;
      if (m_fault) begin
         if (id_ready_i) m_valid = 1'b0;
      end else if (m_halted) begin
         if (id_ready_i) m_valid = 1'b0;
         if (redirect_i) begin
            m_halted = 1'b0;
            m_pc = redirect_pc_i;
         end
      end else if (redirect_i) begin
         m_pc = redirect_pc_i;
         m_valid = 1'b0;
      end else if (int'(m_pc) >= MEM_WORDS) begin
         m_fault = 1'b1;
         if (take) m_valid = 1'b0;
      end else if (take) begin
         word = mem[m_pc[7:0]];
         m_ins = word;
         m_ipc = m_pc;
         m_valid = 1'b1;
         m_pc = m_pc + 16'd1;
         if (word == 16'hFFFF) m_halted = 1'b1;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; leaves the DUT out of reset ready for the next edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic load_program();
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'(i * 3 + 16'h0100);
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
      mem[5] = 16'hFFFF;
      mem[16'h40] = 16'hA040;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, halted_o, fault_o} !== '0) begin
         errors++;
         $display("FAIL reset_values: pc=%h v=%b ins=%h ipc=%h p1=%h h=%b f=%b expected all zero",
                  pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, halted_o, fault_o);
      end
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      id_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (id_valid_o !== 1'b1 || id_ins_o !== 16'(16'h1111 * (i + 1)) ||
             id_pc_o !== 16'(i) || id_pc_plus1_o !== 16'(i + 1) || pc_o !== 16'(i + 1)) begin
            errors++;
            $display("FAIL seq_%0d: v=%b ins=%h ipc=%h p1=%h pc=%h expected 1 %h %h %h %h", i,
                     id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, pc_o,
                     16'(16'h1111 * (i + 1)), 16'(i), 16'(i + 1), 16'(i + 1));
         end
      end
   endtask

   task automatic test_stall();
      @(posedge clk); #1;
      apply_reset();
      step();
      step();
      id_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (id_valid_o !== 1'b1 || id_ins_o !== 16'h2222 || id_pc_o !== 16'd1 ||
             pc_o !== 16'd2) begin
            errors++;
            $display("FAIL stall_hold_%0d: v=%b ins=%h ipc=%h pc=%h expected 1 2222 0001 0002",
                     i, id_valid_o, id_ins_o, id_pc_o, pc_o);
         end
      end
      id_ready_i = 1'b1;
      step();
      checks++;
      if (id_ins_o !== 16'h3333 || id_pc_o !== 16'd2 || pc_o !== 16'd3) begin
         errors++;
         $display("FAIL stall_resume: ins=%h ipc=%h pc=%h expected 3333 0002 0003",
                  id_ins_o, id_pc_o, pc_o);
      end
   endtask

   task automatic test_redirect_stall();
      id_ready_i = 1'b0;
      redirect_i = 1'b1;
      redirect_pc_i = 16'h0040;
      step();
      redirect_i = 1'b0;
      checks++;
      if (id_valid_o !== 1'b0 || pc_o !== 16'h0040) begin
         errors++;
         $display("FAIL redirect_flush: v=%b pc=%h expected 0 0040", id_valid_o, pc_o);
      end
      id_ready_i = 1'b1;
      step();
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== 16'h0040 || id_ins_o !== 16'hA040 ||
          id_pc_plus1_o !== 16'h0041) begin
         errors++;
         $display("FAIL redirect_target: v=%b ipc=%h ins=%h p1=%h expected 1 0040 A040 0041",
                  id_valid_o, id_pc_o, id_ins_o, id_pc_plus1_o);
      end
   endtask

   task automatic test_halt();
      apply_reset();
      id_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (id_valid_o !== 1'b1 || id_ins_o !== 16'hFFFF || id_pc_o !== 16'd5 ||
          halted_o !== 1'b1 || pc_o !== 16'd6) begin
         errors++;
         $display("FAIL halt_capture: v=%b ins=%h ipc=%h h=%b pc=%h expected 1 FFFF 0005 1 0006",
                  id_valid_o, id_ins_o, id_pc_o, halted_o, pc_o);
      end
      step();
      step();
      checks++;
      if (id_valid_o !== 1'b0 || halted_o !== 1'b1 || pc_o !== 16'd6) begin
         errors++;
         $display("FAIL halt_frozen: v=%b h=%b pc=%h expected 0 1 0006",
                  id_valid_o, halted_o, pc_o);
      end
      redirect_i = 1'b1;
      redirect_pc_i = 16'h0000;
      step();
      redirect_i = 1'b0;
      checks++;
      if (halted_o !== 1'b0 || pc_o !== 16'd0) begin
         errors++;
         $display("FAIL halt_exit: h=%b pc=%h expected 0 0000", halted_o, pc_o);
      end
      step();
      checks++;
      if (id_valid_o !== 1'b1 || id_ins_o !== 16'h1111 || id_pc_o !== 16'd0) begin
         errors++;
         $display("FAIL halt_refetch: v=%b ins=%h ipc=%h expected 1 1111 0000",
                  id_valid_o, id_ins_o, id_pc_o);
      end
   endtask

   task automatic test_fault();
      redirect_i = 1'b1;
      redirect_pc_i = 16'h0100;
      step();
      redirect_i = 1'b0;
      checks++;
      if (pc_o !== 16'h0100 || fault_o !== 1'b0 || id_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL fault_pre: pc=%h f=%b v=%b expected 0100 0 0", pc_o, fault_o, id_valid_o);
      end
      step();
      checks++;
      if (fault_o !== 1'b1 || id_valid_o !== 1'b0 || id_pc_o !== 16'd0) begin
         errors++;
         $display("FAIL fault_set: f=%b v=%b ipc=%h expected 1 0 0000",
                  fault_o, id_valid_o, id_pc_o);
      end
      redirect_i = 1'b1;
      redirect_pc_i = 16'h0000;
      step();
      step();
      redirect_i = 1'b0;
      checks++;
      if (fault_o !== 1'b1 || pc_o !== 16'h0100 || id_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL fault_sticky: f=%b pc=%h v=%b expected 1 0100 0",
                  fault_o, pc_o, id_valid_o);
      end
   endtask

   task automatic test_async_reset();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, halted_o, fault_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: pc=%h v=%b ins=%h ipc=%h p1=%h h=%b f=%b expected all zero",
                  pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, halted_o, fault_o);
      end
      model_reset();
      #1;
      rst_n = 1'b1;
      id_ready_i = 1'b1;
      step();
      step();
      checks++;
      if (id_ins_o !== 16'h2222 || id_pc_o !== 16'd1 || fault_o !== 1'b0 || pc_o !== 16'd2) begin
         errors++;
         $display("FAIL async_restart: ins=%h ipc=%h f=%b pc=%h expected 2222 0001 0 0002",
                  id_ins_o, id_pc_o, fault_o, pc_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         mem[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      end
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         id_ready_i = ($urandom_range(0, 3) != 0);
         redirect_i = ($urandom_range(0, 9) == 0);
         redirect_pc_i = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(250, 300))
                                                       : 16'($urandom_range(0, 255));
         step();
         checks++;
         if (pc_o !== m_pc || id_valid_o !== m_valid || id_ins_o !== m_ins ||
             id_pc_o !== m_ipc || id_pc_plus1_o !== 16'(m_ipc + 16'd1) && m_valid ||
             halted_o !== m_halted || fault_o !== m_fault) begin
            errors++;
            $display("FAIL random_%0d: pc=%h v=%b ins=%h ipc=%h p1=%h h=%b f=%b expected %h %b %h %h %h %b %b",
                     c, pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus1_o, halted_o, fault_o,
                     m_pc, m_valid, m_ins, m_ipc, 16'(m_ipc + 16'd1), m_halted, m_fault);
         end
         if (m_fault && $urandom_range(0, 3) == 0) apply_reset();
      end
      redirect_i = 1'b0;
   endtask

   initial begin
      load_program();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_fault();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
